reg_shift_reader: RTL and testbench



---
 rtl/reg_shift_reader_pkg.sv | 20 ++
 rtl/reg_shift_reader_if.sv | 29 ++
 rtl/reg_shift_reader_bit_counter.sv | 37 +++
 rtl/reg_shift_reader.sv | 106 ++++++++++
 tb/tb_reg_shift_reader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_shift_reader_pkg.sv
// Shared definitions for the parallel-in / serial-out register reader:
// FSM state encoding and the counter width derivation.
package reg_shift_reader_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

  // Bit-count width; a one-bit word still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 32'sd1) ? $clog2(width) : 32'sd1;
  endfunction

endpackage

// File: rtl/reg_shift_reader_if.sv
// Start/capture request plus serial valid/ready stream of the register reader.
interface reg_shift_reader_if
  import reg_shift_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = cnt_width(WIDTH)
);

  logic             i_start;
  logic [WIDTH-1:0] i_d;
  logic             i_ready;
  logic             o_valid;
  logic             o_bit;
  logic             o_last;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_count;

  modport slave (
    input  i_start, i_d, i_ready,
    output o_valid, o_bit, o_last, o_busy, o_done, o_count
  );

  modport master (
    output i_start, i_d, i_ready,
    input  o_valid, o_bit, o_last, o_busy, o_done, o_count
  );

endinterface

// File: rtl/reg_shift_reader_bit_counter.sv
// Accepted-bit counter: clears on capture, wraps to zero on the terminal bit.
module bit_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             srstn,
  input  logic             clear,
  input  logic             incr,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] count,
  output logic             at_term
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1'b1);

  logic [CNT_W-1:0] count_r;

  // Count register with async and sync reset.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count_r <= '0;
    end else if (!srstn) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (incr) begin
      count_r <= at_term ? '0 : (count_r + ONE);
    end else begin
      count_r <= count_r;
    end
  end

  assign count   = count_r;
  assign at_term = (count_r == terminal);

endmodule

// File: rtl/reg_shift_reader.sv
// Parallel-in, serial-out register reader with valid/ready output stream
// and a one-cycle done pulse after the final accepted bit.
module reg_shift_reader
  import reg_shift_reader_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MSB_FIRST = 1
) (
  input  logic               i_clk,
  input  logic               i_arstn,
  input  logic               i_srstn,
  reg_shift_reader_if.slave  bus
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nx;
  logic [WIDTH-1:0] shreg_r;
  logic             capture_s;
  logic             xfer_s;
  logic             at_term_s;
  logic             out_bit_s;
  logic [CNT_W-1:0] count_s;

  // Next-state and transfer decode.
  always_comb begin
    state_nx  = state_r;
    capture_s = 1'b0;
    xfer_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_start) begin
          capture_s = 1'b1;
          state_nx  = ST_SHIFT;
        end else begin
          state_nx  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.i_ready) begin
          xfer_s   = 1'b1;
          state_nx = at_term_s ? ST_DONE : ST_SHIFT;
        end else begin
          state_nx = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_r <= ST_IDLE;
    end else if (!i_srstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Shift register moves towards the output end, zero-filled.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      shreg_r <= '0;
    end else if (!i_srstn) begin
      shreg_r <= '0;
    end else if (capture_s) begin
      shreg_r <= bus.i_d;
    end else if (xfer_s) begin
      shreg_r <= (MSB_FIRST != 0) ? (shreg_r << 1'b1) : (shreg_r >> 1'b1);
    end else begin
      shreg_r <= shreg_r;
    end
  end

  bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (i_clk),
    .arstn    (i_arstn),
    .srstn    (i_srstn),
    .clear    (capture_s),
    .incr     (xfer_s),
    .terminal (TERM),
    .count    (count_s),
    .at_term  (at_term_s)
  );

  assign out_bit_s   = (MSB_FIRST != 0) ? shreg_r[WIDTH-1] : shreg_r[0];

  assign bus.o_valid = (state_r == ST_SHIFT);
  assign bus.o_bit   = (state_r == ST_SHIFT) & out_bit_s;
  assign bus.o_last  = (state_r == ST_SHIFT) & at_term_s;
  assign bus.o_busy  = (state_r != ST_IDLE);
  assign bus.o_done  = (state_r == ST_DONE);
  assign bus.o_count = count_s;

endmodule

// File: tb/tb_reg_shift_reader.sv
// Runs three readers (8-bit MSB-first, 8-bit LSB-first, 1-bit) in lockstep
// from shared stimulus and compares each against a per-instance word/index model.
module tb_reg_shift_reader;

  logic       clk;
  logic       arstn;
  logic       srstn;
  logic       start;
  logic       ready;
  logic [7:0] d;

  int checks   = 0;
  int failures = 0;

  reg_shift_reader_if #(.WIDTH(8)) bus_msb ();
  reg_shift_reader_if #(.WIDTH(8)) bus_lsb ();
  reg_shift_reader_if #(.WIDTH(1)) bus_w1 ();

  assign bus_msb.i_start = start;
  assign bus_msb.i_d     = d;
  assign bus_msb.i_ready = ready;
  assign bus_lsb.i_start = start;
  assign bus_lsb.i_d     = d;
  assign bus_lsb.i_ready = ready;
  assign bus_w1.i_start  = start;
  assign bus_w1.i_d      = d[0];
  assign bus_w1.i_ready  = ready;

  reg_shift_reader #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .i_clk(clk), .i_arstn(arstn), .i_srstn(srstn), .bus(bus_msb));
  reg_shift_reader #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .i_clk(clk), .i_arstn(arstn), .i_srstn(srstn), .bus(bus_lsb));
  reg_shift_reader #(.WIDTH(1), .MSB_FIRST(1)) u_w1 (
    .i_clk(clk), .i_arstn(arstn), .i_srstn(srstn), .bus(bus_w1));

  logic obs_valid [3];
  logic obs_bit   [3];
  logic obs_last  [3];
  logic obs_busy  [3];
  logic obs_done  [3];
  int   obs_count [3];

  assign obs_valid[0] = bus_msb.o_valid;
  assign obs_valid[1] = bus_lsb.o_valid;
  assign obs_valid[2] = bus_w1.o_valid;
  assign obs_bit[0]   = bus_msb.o_bit;
  assign obs_bit[1]   = bus_lsb.o_bit;
  assign obs_bit[2]   = bus_w1.o_bit;
  assign obs_last[0]  = bus_msb.o_last;
  assign obs_last[1]  = bus_lsb.o_last;
  assign obs_last[2]  = bus_w1.o_last;
  assign obs_busy[0]  = bus_msb.o_busy;
  assign obs_busy[1]  = bus_lsb.o_busy;
  assign obs_busy[2]  = bus_w1.o_busy;
  assign obs_done[0]  = bus_msb.o_done;
  assign obs_done[1]  = bus_lsb.o_done;
  assign obs_done[2]  = bus_w1.o_done;
  assign obs_count[0] = int'(bus_msb.o_count);
  assign obs_count[1] = int'(bus_lsb.o_count);
  assign obs_count[2] = int'(bus_w1.o_count);

  // Model: captured word, number of bits accepted, streaming / done-pending flags.
  int         m_w   [3] = '{8, 8, 1};
  bit         m_msb [3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] m_word   [3];
  int         m_idx    [3];
  bit         m_active [3];
  bit         m_done   [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_word[k]   = 8'h00;
      m_idx[k]    = 0;
      m_active[k] = 1'b0;
      m_done[k]   = 1'b0;
    end
  endtask

  task automatic model_step(input logic s_start, input logic s_ready,
                            input logic [7:0] s_d, input logic s_srstn);
    if (!arstn || !s_srstn) begin
      model_reset();
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_done[k]) begin
          m_done[k] = 1'b0;
        end else if (m_active[k]) begin
          if (s_ready) begin
            if (m_idx[k] + 1 == m_w[k]) begin
              m_active[k] = 1'b0;
              m_done[k]   = 1'b1;
              m_idx[k]    = 0;
            end else begin
              m_idx[k] = m_idx[k] + 1;
            end
          end
        end else if (s_start) begin
          m_word[k]   = (m_w[k] == 1) ? {7'd0, s_d[0]} : s_d;
          m_idx[k]    = 0;
          m_active[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp_bit(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0b expected=%0b t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic cmp_int(input string tag, input int k, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      logic eb;
      eb = 1'b0;
      if (m_active[k]) begin
        eb = m_msb[k] ? m_word[k][m_w[k] - 1 - m_idx[k]] : m_word[k][m_idx[k]];
      end
      cmp_bit("valid", k, obs_valid[k], m_active[k]);
      cmp_bit("bit",   k, obs_bit[k],   eb);
      cmp_bit("last",  k, obs_last[k],  m_active[k] && (m_idx[k] == m_w[k] - 1));
      cmp_bit("busy",  k, obs_busy[k],  m_active[k] || m_done[k]);
      cmp_bit("done",  k, obs_done[k],  m_done[k]);
      cmp_int("count", k, obs_count[k], m_active[k] ? m_idx[k] : 0);
    end
  endtask

  task automatic tick();
    logic       s_start;
    logic       s_ready;
    logic [7:0] s_d;
    logic       s_srstn;
    s_start = start;
    s_ready = ready;
    s_d     = d;
    s_srstn = srstn;
    @(posedge clk);
    model_step(s_start, s_ready, s_d, s_srstn);
    #1;
    check_all();
  endtask

  task automatic run_until_idle(input int budget, input bit toggle_ready);
    int n;
    n = 0;
    while ((m_active[0] || m_done[0] || m_active[1] || m_done[1] ||
            m_active[2] || m_done[2]) && n < budget) begin
      if (toggle_ready) ready = ~ready;
      tick();
      n++;
    end
    cmp_int("drain_timeout", 0, (n < budget) ? 1 : 0, 1);
  endtask

  task automatic pulse_start(input logic [7:0] word);
    d     = word;
    start = 1'b1;
    tick();
    start = 1'b0;
    d     = 8'($urandom);
  endtask

  initial begin
    arstn = 1'b0;
    srstn = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    d     = 8'h00;
    model_reset();
    #2;
    check_all();
    tick();
    tick();
    #2 arstn = 1'b1;
    tick();

    // Basic A5 with ready high, then 01 (exercises bit order).
    ready = 1'b1;
    pulse_start(8'hA5);
    run_until_idle(20, 1'b0);
    tick();
    pulse_start(8'h01);
    run_until_idle(20, 1'b0);

    // Backpressure: stall three cycles, then toggle ready.
    ready = 1'b0;
    pulse_start(8'h80);
    tick();
    tick();
    tick();
    run_until_idle(40, 1'b1);

    // Start during SHIFT and during DONE is ignored.
    ready = 1'b1;
    pulse_start(8'h00);
    tick();
    tick();
    pulse_start(8'hFF);
    while ((m_active[0] || !m_done[0])) tick();
    pulse_start(8'hFF);
    tick();
    pulse_start(8'h3C);
    run_until_idle(20, 1'b0);

    // Asynchronous reset after three accepted bits.
    pulse_start(8'hFF);
    tick();
    tick();
    tick();
    #2 arstn = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    #2 arstn = 1'b1;
    tick();
    tick();

    // Synchronous reset for one cycle after three accepted bits.
    pulse_start(8'hC3);
    tick();
    tick();
    tick();
    srstn = 1'b0;
    tick();
    srstn = 1'b1;
    tick();
    tick();

    // Randomized traffic with occasional synchronous resets.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) != 0);
      d     = 8'($urandom);
      srstn = ($urandom_range(0, 79) != 0);
      tick();
    end
    start = 1'b0;
    srstn = 1'b1;
    ready = 1'b1;
    run_until_idle(40, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
